// File: rtl/flex_fifo.sv
// flex_fifo: single-clock FIFO with level flags, sticky errors and registered or FWFT read
module flex_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH_PACKET = 13,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int FWFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [WIDTH_PACKET-1:0] wr_data,
  input  logic                    rd_en,
  input  logic                    clr_err,
  output logic [WIDTH_PACKET-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH_PACKET-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [WIDTH_PACKET-1:0] rd_q;
  logic rv_q, rd_acc, wr_acc;
  always_comb begin
    full = level == LW'(DEPTH);
    empty = level == '0;
    almost_full = level >= LW'(AF_THRESH);
    almost_empty = level <= LW'(AE_THRESH);
    rd_acc = rd_en && !empty;
    wr_acc = wr_en && (!full || rd_acc);
    rd_data = FWFT != 0 ? mem[rd_ptr] : rd_q;
    rd_valid = FWFT != 0 ? !empty : rv_q;
  end
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      rd_q <= '0;
      rv_q <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_acc);
      rd_ptr <= rd_ptr + AW'(rd_acc);
      level <= level + LW'(wr_acc) - LW'(rd_acc);
      rv_q <= rd_acc;
      if (rd_acc) rd_q <= mem[rd_ptr];
      // a same-cycle error event beats clr_err
      overflow <= (wr_en && !wr_acc) || (overflow && !clr_err);
      underflow <= (rd_en && empty) || (underflow && !clr_err);
    end
endmodule

// File: tb/tb_flex_fifo.sv
// tb_flex_fifo: directed checks of a DEPTH=4 FIFO in registered-read and FWFT modes
module tb_flex_fifo;
  logic clk = 0, rst = 1, wr_en = 0, rd_en = 0, clr_err = 0;
  logic [12:0] wr_data = '0;
  logic [12:0] rd_data0, rd_data1;
  logic rd_valid0, rd_valid1, full0, full1, empty0, empty1, af0, af1, ae0, ae1;
  logic ovf0, ovf1, udf0, udf1;
  logic [2:0] level0, level1;
  int passed = 0, total = 0;
  logic [12:0] exp_q [4];

  flex_fifo #(.DEPTH(4), .WIDTH_PACKET(13), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .level(level0), .overflow(ovf0), .underflow(udf0));

  flex_fifo #(.DEPTH(4), .WIDTH_PACKET(13), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .level(level1), .overflow(ovf1), .underflow(udf1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic fill4;
    wr_en = 1;
    for (int i = 1; i <= 4; i++) begin
      wr_data = 13'(i);
      cyc;
    end
    wr_en = 0;
  endtask

  initial begin
    #3;
    chk("rst_level", 16'(level0), 0);
    chk("rst_empty", 16'(empty0), 1);
    chk("rst_full", 16'(full0), 0);
    chk("rst_ae", 16'(ae0), 1);
    chk("rst_af", 16'(af0), 0);
    chk("rst_rv0", 16'(rd_valid0), 0);
    chk("rst_rv1", 16'(rd_valid1), 0);
    chk("rst_rd0", 16'(rd_data0), 0);
    #9 rst = 0;
    // fill
    wr_en = 1;
    for (int i = 1; i <= 4; i++) begin
      wr_data = 13'(i);
      cyc;
      chk("fill_level", 16'(level0), 16'(i));
      chk("fill_ae", 16'(ae0), 16'(i <= 1));
      chk("fill_af", 16'(af0), 16'(i >= 3));
      chk("fill_full", 16'(full0), 16'(i == 4));
    end
    wr_data = 13'h005;
    cyc;
    wr_en = 0;
    chk("fill_ovf", 16'(ovf0), 1);
    chk("fill_ovf_level", 16'(level0), 4);
    // drain
    rd_en = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("fwft_head", 16'(rd_data1), 16'(i));
      cyc;
      chk("drain_data", 16'(rd_data0), 16'(i));
      chk("drain_valid", 16'(rd_valid0), 1);
    end
    cyc;
    rd_en = 0;
    chk("drain_udf", 16'(udf0), 1);
    chk("drain_udf_rv", 16'(rd_valid0), 0);
    chk("drain_hold", 16'(rd_data0), 16'h004);
    cyc;
    chk("rv_pulse_end", 16'(rd_valid0), 0);
    clr_err = 1;
    cyc;
    clr_err = 0;
    chk("clr_ovf", 16'(ovf0), 0);
    chk("clr_udf", 16'(udf0), 0);
    // full with simultaneous push and pop
    fill4;
    wr_en = 1;
    rd_en = 1;
    wr_data = 13'h0AB;
    cyc;
    wr_en = 0;
    chk("simul_level", 16'(level0), 4);
    chk("simul_ovf", 16'(ovf0), 0);
    chk("simul_data", 16'(rd_data0), 16'h001);
    exp_q = '{13'h002, 13'h003, 13'h004, 13'h0AB};
    for (int i = 0; i < 4; i++) begin
      cyc;
      chk("simul_drain", 16'(rd_data0), 16'(exp_q[i]));
    end
    rd_en = 0;
    // wrap: push/pop pairs at level 1
    wr_en = 1;
    wr_data = 13'h010;
    cyc;
    rd_en = 1;
    for (int i = 1; i < 12; i++) begin
      wr_data = 13'(16'h010 + i);
      cyc;
      chk("wrap_data", 16'(rd_data0), 16'(16'h010 + i - 1));
      chk("wrap_level", 16'(level0), 1);
    end
    wr_en = 0;
    cyc;
    rd_en = 0;
    chk("wrap_last", 16'(rd_data0), 16'h01B);
    chk("wrap_empty", 16'(empty0), 1);
    // FWFT
    wr_en = 1;
    wr_data = 13'h0AA;
    cyc;
    wr_en = 0;
    chk("fwft_data", 16'(rd_data1), 16'h0AA);
    chk("fwft_valid", 16'(rd_valid1), 1);
    chk("reg_no_valid", 16'(rd_valid0), 0);
    rd_en = 1;
    cyc;
    rd_en = 0;
    chk("fwft_pop_valid", 16'(rd_valid1), 0);
    chk("reg_pop_data", 16'(rd_data0), 16'h0AA);
    // reset mid-operation with 3 entries and overflow set
    fill4;
    wr_en = 1;
    wr_data = 13'h1FF;
    cyc;
    wr_en = 0;
    rd_en = 1;
    cyc;
    rd_en = 0;
    chk("pre_rst_level", 16'(level0), 3);
    chk("pre_rst_ovf", 16'(ovf0), 1);
    #2 rst = 1;
    #1;
    chk("arst_level", 16'(level0), 0);
    chk("arst_empty", 16'(empty0), 1);
    chk("arst_ovf", 16'(ovf0), 0);
    chk("arst_fwft_rv", 16'(rd_valid1), 0);
    chk("arst_rd0", 16'(rd_data0), 0);
    rst = 0;
    cyc;
    wr_en = 1;
    wr_data = 13'h155;
    cyc;
    wr_en = 0;
    chk("post_rst_fwft", 16'(rd_data1), 16'h155);
    rd_en = 1;
    cyc;
    rd_en = 0;
    chk("post_rst_data", 16'(rd_data0), 16'h155);
    chk("post_rst_empty", 16'(empty0), 1);
    // overflow then clear, and set beating clear
    fill4;
    wr_en = 1;
    cyc;
    wr_en = 0;
    chk("ovf_again", 16'(ovf0), 1);
    clr_err = 1;
    cyc;
    chk("ovf_cleared", 16'(ovf0), 0);
    wr_en = 1;
    cyc;
    wr_en = 0;
    clr_err = 0;
    chk("set_wins", 16'(ovf0), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/flex_fifo.md
FLEX_FIFO -- requirements
Module: flex_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count, power of two, >= 2.
REQ-002 SHALL have parameter WIDTH_PACKET, default 13, data width in bits.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-1, almost_full level threshold, 1..DEPTH.
REQ-004 SHALL have parameter AE_THRESH, default 1, almost_empty level threshold, 0..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-008 SHALL have port wr_en  input  1  push request.
REQ-009 SHALL have port wr_data  input  WIDTH_PACKET  push data.
REQ-010 SHALL have port rd_en  input  1  pop request.
REQ-011 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-012 SHALL have port rd_data  output  WIDTH_PACKET  read data.
REQ-013 SHALL have port rd_valid  output  1  rd_data qualifier.
REQ-014 SHALL have port full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 SHALL have port level  output  $clog2(DEPTH)+1  current entry count.
REQ-016 SHALL have port overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 SHALL define rd_acc = rd_en && !empty, and wr_acc = wr_en && (!full || rd_acc), so a push into a full FIFO is accepted when a pop is accepted in the same cycle.
REQ-018 SHALL write wr_data to mem[wr_ptr] and advance wr_ptr modulo DEPTH only on wr_acc; a rejected push changes no state except overflow.
REQ-019 SHALL advance rd_ptr modulo DEPTH only on rd_acc.
REQ-020 SHALL update level as registered count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
REQ-021 SHALL decode flags combinationally from registered level: full = (level==DEPTH), empty = (level==0), almost_full = (level>=AF_THRESH), almost_empty = (level<=AE_THRESH).
REQ-022 SHALL, when FWFT=0, load rd_data with mem[rd_ptr] on rd_acc and pulse rd_valid high for exactly the following cycle; rd_data SHALL hold its last value otherwise.
REQ-023 SHALL, when FWFT=1, drive rd_data = mem[rd_ptr] and rd_valid = !empty continuously; rd_en acts as a pop acknowledge; a word written into an empty FIFO SHALL appear on rd_data the cycle after the write edge.
REQ-024 SHALL preserve strict write order on read across pointer wrap-around.
REQ-025 SHALL set overflow on any cycle with wr_en && !wr_acc, and set underflow on any cycle with rd_en && empty.
REQ-026 SHALL clear overflow and underflow on clr_err; a same-cycle set SHALL win over clear.
REQ-027 SHALL NOT reset memory contents.

Reset
REQ-028 SHALL, while rst is high and independent of clk, force wr_ptr=0, rd_ptr=0, level=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
REQ-029 SHALL therefore present empty=1, full=0, almost_empty=1, almost_full=0 during reset; with FWFT=1, rd_valid=0.
REQ-030 SHALL discard all stored entries when reset is asserted mid-operation; the first read after deassertion SHALL return only data written after deassertion.

Verification (DEPTH=4, WIDTH_PACKET=13, AF_THRESH=3, AE_THRESH=1)
REQ-031 Fill: push 0x001..0x004 -> level 1,2,3,4; almost_empty drops at level 2; almost_full rises at 3; full at 4; fifth push 0x005 -> overflow=1, level stays 4.
REQ-032 Drain, FWFT=0: four pops -> rd_data 0x001..0x004, each with rd_valid one cycle after rd_en; fifth pop -> underflow=1, rd_valid=0, rd_data holds 0x004.
REQ-033 Full plus simultaneous push 0x0AB and pop -> both accepted, level stays 4, overflow stays 0; subsequent drain yields 0x002,0x003,0x004,0x0AB.
REQ-034 Wrap: 12 single push/pop pairs 0x010..0x01B at level 1-2 -> output in order with no loss; level never exceeds 2.
REQ-035 FWFT=1: push 0x0AA into empty -> next cycle rd_data=0x0AA, rd_valid=1 with rd_en low; pop -> rd_valid=0 the following cycle.
REQ-036 Reset mid-operation: 3 entries stored and overflow set, assert rst between edges -> immediately level=0, empty=1, overflow=0; after release, push 0x155 and pop -> rd_data=0x155; clr_err on a later overflow clears it.
